// File: rtl/ram_miss_arbiter_if.sv
// Bundle of the icache, dcache and RAM signals around the miss arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and RAM.
interface ram_miss_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_ack;
   logic              busy;
   logic              err;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ack,
      output i_rdata, i_done, d_rdata, d_done, ram_req, ram_we, ram_addr, ram_wdata,
             busy, err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_ack,
      input  i_rdata, i_done, d_rdata, d_done, ram_req, ram_we, ram_addr, ram_wdata,
             busy, err
   );
endinterface

// File: rtl/ram_miss_arbiter.sv
// Round-robin arbiter sharing one 64-bit RAM port between icache and dcache misses.
// Optional ARB_TIMEOUT_EN macro adds a busy-cycle watchdog with a sticky err flag.
module ram_miss_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                reset,
   ram_miss_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t            state_reg, state_next;
   // 1 = dcache; also identifies the owner of the current transaction
   logic              last_grant_reg, last_grant_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
   logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
   logic              grant_d;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]        cnt_reg, cnt_next;
   logic              err_reg, err_next;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         i_rdata_reg    <= '0;
         d_rdata_reg    <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_reg        <= '0;
         err_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         i_rdata_reg    <= i_rdata_next;
         d_rdata_reg    <= d_rdata_next;
`ifdef ARB_TIMEOUT_EN
         cnt_reg        <= cnt_next;
         err_reg        <= err_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      i_rdata_next    = i_rdata_reg;
      d_rdata_next    = d_rdata_reg;
      grant_d         = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_next        = cnt_reg;
      err_next        = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               // On a tie the requester that did not win last time goes first
               grant_d         = bus.d_req && (!bus.i_req || !last_grant_reg);
               last_grant_next = grant_d;
               we_next         = grant_d && bus.d_we;
               addr_next       = grant_d ? bus.d_addr : bus.i_addr;
               addr_next[2:0]  = 3'b000;
               wdata_next      = grant_d ? bus.d_wdata : '0;
               state_next      = grant_d ? BUSY_D : BUSY_I;
`ifdef ARB_TIMEOUT_EN
               cnt_next        = '0;
`endif
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.ram_ack) begin
               state_next = DONE;
               if (!we_reg) begin
                  if (state_reg == BUSY_D) d_rdata_next = bus.ram_rdata;
                  else                     i_rdata_next = bus.ram_rdata;
               end
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_reg == TIMEOUT_LAST) begin
               // Give up on the RAM: complete with a zero block and flag it
               state_next = DONE;
               err_next   = 1'b1;
               if (state_reg == BUSY_D) d_rdata_next = '0;
               else                     i_rdata_next = '0;
            end else begin
               cnt_next = cnt_reg + 8'd1;
`endif
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.ram_req   = (state_reg == BUSY_I) || (state_reg == BUSY_D);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.i_done    = (state_reg == DONE) && !last_grant_reg;
   assign bus.d_done    = (state_reg == DONE) && last_grant_reg;
   assign bus.ram_we    = we_reg;
   assign bus.ram_addr  = addr_reg;
   assign bus.ram_wdata = wdata_reg;
   assign bus.i_rdata   = i_rdata_reg;
   assign bus.d_rdata   = d_rdata_reg;
`ifdef ARB_TIMEOUT_EN
   assign bus.err       = err_reg;
`else
   assign bus.err       = 1'b0;
`endif

endmodule
